// File: rtl/ifft_butterfly_pipe.sv
// Pipelined radix-2 inverse butterfly.
// Recovers E = (S + D) / 2 and O = conj(W) * (S - D) / (2 * TWIDDLE_SCALE)
// from a forward butterfly result pair, one butterfly per cycle, 3-stage latency.
// All stages advance together when the output is free or being taken.
module ifft_butterfly_pipe #(
    parameter int SAMPLE_W      = 32,
    parameter int TWIDDLE_W     = 16,
    parameter int TWIDDLE_SCALE = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SAMPLE_W-1:0]  sum_real,
    input  logic signed [SAMPLE_W-1:0]  sum_imag,
    input  logic signed [SAMPLE_W-1:0]  diff_real,
    input  logic signed [SAMPLE_W-1:0]  diff_imag,
    input  logic signed [TWIDDLE_W-1:0] tw_real,
    input  logic signed [TWIDDLE_W-1:0] tw_imag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [SAMPLE_W-1:0]  even_real,
    output logic signed [SAMPLE_W-1:0]  even_imag,
    output logic signed [SAMPLE_W-1:0]  odd_real,
    output logic signed [SAMPLE_W-1:0]  odd_imag,
    output logic                        sat_flag,
    input  logic                        sat_clear
);

    localparam int AW = SAMPLE_W + 1;
    localparam int PW = SAMPLE_W + TWIDDLE_W + 2;

    localparam logic signed [PW-1:0] ODIV = PW'(2 * TWIDDLE_SCALE);
    localparam logic signed [PW-1:0] OMAX = {{(PW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [PW-1:0] OMIN = {{(PW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic adv;

    // global stall: the whole pipe moves only when stage 3 can hand off
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: a = S + D, d = S - D ----------------
    logic signed [AW-1:0] sr_x, si_x, dr_x, di_x;
    assign sr_x = {sum_real[SAMPLE_W-1],  sum_real};
    assign si_x = {sum_imag[SAMPLE_W-1],  sum_imag};
    assign dr_x = {diff_real[SAMPLE_W-1], diff_real};
    assign di_x = {diff_imag[SAMPLE_W-1], diff_imag};

    logic                        s1_valid;
    logic signed [AW-1:0]        s1_ar, s1_ai, s1_dr, s1_di;
    logic signed [TWIDDLE_W-1:0] s1_wr, s1_wi;

    // stage 1 register: widened sum/difference plus the twiddle travelling alongside
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_dr    <= '0;
            s1_di    <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_ar    <= sr_x + dr_x;
            s1_ai    <= si_x + di_x;
            s1_dr    <= sr_x - dr_x;
            s1_di    <= si_x - di_x;
            s1_wr    <= tw_real;
            s1_wi    <= tw_imag;
        end
    end

    // ---------------- stage 2: conj(W) * d, E = a >>> 1 ----------------
    logic signed [PW-1:0] dr_p, di_p, wr_p, wi_p, pr_n, pi_n;
    assign dr_p = {{(PW-AW){s1_dr[AW-1]}}, s1_dr};
    assign di_p = {{(PW-AW){s1_di[AW-1]}}, s1_di};
    assign wr_p = {{(PW-TWIDDLE_W){s1_wr[TWIDDLE_W-1]}}, s1_wr};
    assign wi_p = {{(PW-TWIDDLE_W){s1_wi[TWIDDLE_W-1]}}, s1_wi};
    assign pr_n = dr_p * wr_p + di_p * wi_p;
    assign pi_n = di_p * wr_p - dr_p * wi_p;

    // halving a is just dropping its LSB; the 33-bit range always fits back in SAMPLE_W
    logic unused_lsbs;
    assign unused_lsbs = s1_ar[0] ^ s1_ai[0];

    logic                       s2_valid;
    logic signed [SAMPLE_W-1:0] s2_er, s2_ei;
    logic signed [PW-1:0]       s2_pr, s2_pi;

    // stage 2 register: full-precision products and the halved even term
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_er    <= '0;
            s2_ei    <= '0;
            s2_pr    <= '0;
            s2_pi    <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_er    <= s1_ar[AW-1:1];
            s2_ei    <= s1_ai[AW-1:1];
            s2_pr    <= pr_n;
            s2_pi    <= pi_n;
        end
    end

    // ---------------- stage 3: scale, clamp, output ----------------
    // returns {saturated, clamped value}
    function automatic logic [SAMPLE_W:0] clamp_o(input logic signed [PW-1:0] q);
        logic [SAMPLE_W:0] r;
        r = {1'b0, q[SAMPLE_W-1:0]};
        if (q > OMAX) begin
            r = {1'b1, OMAX[SAMPLE_W-1:0]};
        end else if (q < OMIN) begin
            r = {1'b1, OMIN[SAMPLE_W-1:0]};
        end
        return r;
    endfunction

    logic signed [PW-1:0] qr, qi;
    logic [SAMPLE_W:0]    cr, ci;
    logic                 sat_now;

    // signed divide truncates toward zero, matching the forward scaling
    assign qr      = s2_pr / ODIV;
    assign qi      = s2_pi / ODIV;
    assign cr      = clamp_o(qr);
    assign ci      = clamp_o(qi);
    assign sat_now = cr[SAMPLE_W] | ci[SAMPLE_W];

    // output register: held while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            even_real <= '0;
            even_imag <= '0;
            odd_real  <= '0;
            odd_imag  <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            even_real <= s2_er;
            even_imag <= s2_ei;
            odd_real  <= cr[SAMPLE_W-1:0];
            odd_imag  <= ci[SAMPLE_W-1:0];
        end
    end

    // sticky saturation flag; a new saturating butterfly beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (adv && s2_valid && sat_now) begin
            sat_flag <= 1'b1;
        end else if (sat_clear) begin
            sat_flag <= 1'b0;
        end
    end

endmodule
